// File: rtl/dm_ctrl.sv
// Handshaked, parametrised MIPS data memory with byte lanes, load extension and post-reset clear sweep.
// Optional store trace is compiled in when the DM_TRACE_EN macro is defined.
module dm_ctrl #(
  parameter int ADDR_W         = 12,
  parameter int LATENCY        = 1,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {CLEAR, IDLE, WAIT} state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] clr_idx;
  logic [3:0]        cnt;
  logic [31:0]       mem [0:(1<<ADDR_W)-1];

  logic              accept, err;
  logic [ADDR_W-1:0] word_idx;
  logic [31:0]       cur_word, lane_data, merged_word, load_data;
  logic [3:0]        lane_mask;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [31:0]       held_rdata;
  logic              held_err;
  logic              unused_bits;

  assign word_idx  = req_addr[ADDR_W+1:2];
  assign cur_word  = mem[word_idx];
  assign req_ready = (state == IDLE);
  assign busy      = !req_ready;
  assign accept    = req_valid && req_ready;

  // Upper address bits wrap and the PC only feeds the optional trace.
  assign unused_bits = ^{req_pc, req_addr[31:ADDR_W+2]};

  always_comb begin
    err = ((req_size == 2'b01) && req_addr[0]) ||
          ((req_size == 2'b10) && (req_addr[1:0] != 2'b00)) ||
          (req_size == 2'b11);
  end

  // Store data is replicated across lanes so the mask alone picks the target bytes.
  always_comb begin
    lane_mask   = 4'b0000;
    lane_data   = 32'h0;
    merged_word = cur_word;
    case (req_size)
      2'b00: begin
        lane_mask = 4'b0001 << req_addr[1:0];
        lane_data = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        lane_mask = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        lane_mask = 4'b1111;
        lane_data = req_wdata;
      end
      default: ;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (lane_mask[i]) merged_word[8*i +: 8] = lane_data[8*i +: 8];
    end
  end

  always_comb begin
    ld_byte   = cur_word[{req_addr[1:0], 3'b000} +: 8];
    ld_half   = req_addr[1] ? cur_word[31:16] : cur_word[15:0];
    load_data = 32'h0;
    case (req_size)
      2'b00:   load_data = {{24{req_signed & ld_byte[7]}}, ld_byte};
      2'b01:   load_data = {{16{req_signed & ld_half[15]}}, ld_half};
      2'b10:   load_data = cur_word;
      default: load_data = 32'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= CLEAR_ON_RESET ? CLEAR : IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      CLEAR:   if (clr_idx == '1) next_state = IDLE;
      IDLE:    if (req_valid) next_state = WAIT;
      WAIT:    if (cnt <= 4'd1) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_idx    <= '0;
      cnt        <= 4'd0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 32'h0;
      rsp_err    <= 1'b0;
      held_rdata <= 32'h0;
      held_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        CLEAR: clr_idx <= clr_idx + 1'b1;
        IDLE: begin
          if (accept) begin
            cnt        <= 4'(LATENCY);
            held_err   <= err;
            held_rdata <= (req_write || err) ? 32'h0 : load_data;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= held_rdata;
            rsp_err   <= held_err;
          end
        end
        default: ;
      endcase
    end
  end

  // The array has no reset of its own; the sweep clears it instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR)
        mem[clr_idx] <= 32'h0;
      else if (accept && req_write && !err)
        mem[word_idx] <= merged_word;
    end
  end

`ifdef DM_TRACE_EN
  always_ff @(posedge clk) begin
    if (!reset && accept && req_write && !err)
      $display("%d@%h: *%h <= %h", $time, req_pc, {req_addr[31:2], 2'b00}, merged_word);
  end
`else
`endif

endmodule

// File: tb/tb_dm_ctrl.sv
// Bench for dm_ctrl: three 16-word instances (latency 1, 3, 4) checked against a byte-array model.
module tb_dm_ctrl;

  localparam int NDUT = 3;

  typedef struct packed {
    logic        wr;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
  } op_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [NDUT];
  logic        req_write [NDUT];
  logic [1:0]  req_size  [NDUT];
  logic        req_signed[NDUT];
  logic [31:0] req_addr  [NDUT];
  logic [31:0] req_wdata [NDUT];
  logic [31:0] req_pc    [NDUT];
  logic        req_ready [NDUT];
  logic        rsp_valid [NDUT];
  logic [31:0] rsp_rdata [NDUT];
  logic        rsp_err   [NDUT];
  logic        busy      [NDUT];

  logic [7:0]  mb [NDUT][64];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dm_ctrl #(
      .ADDR_W(4),
      .LATENCY(g == 0 ? 1 : (g == 1 ? 3 : 4)),
      .CLEAR_ON_RESET(1'b1)
    ) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid[g]), .req_ready(req_ready[g]),
      .req_write(req_write[g]), .req_size(req_size[g]),
      .req_signed(req_signed[g]), .req_addr(req_addr[g]),
      .req_wdata(req_wdata[g]), .req_pc(req_pc[g]),
      .rsp_valid(rsp_valid[g]), .rsp_rdata(rsp_rdata[g]),
      .rsp_err(rsp_err[g]), .busy(busy[g])
    );
  end

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : ((d == 1) ? 3 : 4);
  endfunction

  function automatic logic model_err(op_t op);
    return (op.sz == 2'd3) || (op.sz == 2'd1 && op.addr[0]) ||
           (op.sz == 2'd2 && op.addr[1:0] != 2'd0);
  endfunction

  // Byte-addressed little-endian memory; returns the load result (0 for stores/errors).
  function automatic logic [31:0] model_access(int d, op_t op);
    int          nb, base;
    logic [31:0] v;
    v = 32'h0;
    if (model_err(op)) return 32'h0;
    nb   = 1 << op.sz;
    base = int'(op.addr % 64);
    for (int i = 0; i < nb; i++) begin
      if (op.wr) mb[d][base + i] = op.wd[8*i +: 8];
      else       v[8*i +: 8] = mb[d][base + i];
    end
    if (op.wr) return 32'h0;
    if (op.sg && nb < 4 && v[8*nb-1])
      for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < NDUT; d++)
      for (int i = 0; i < 64; i++) mb[d][i] = 8'h00;
  endtask

  task automatic drive(int d, op_t op);
    req_write[d]  = op.wr;
    req_size[d]   = op.sz;
    req_signed[d] = op.sg;
    req_addr[d]   = op.addr;
    req_wdata[d]  = op.wd;
    req_pc[d]     = 32'h0040_0000 + {op.addr[7:0], 2'b00};
  endtask

  function automatic op_t rand_op();
    op_t op;
    op.wr   = 1'($urandom_range(0, 1));
    op.sz   = 2'($urandom_range(0, 3));
    op.sg   = 1'($urandom_range(0, 1));
    op.addr = 32'($urandom_range(0, 255));
    op.wd   = $urandom;
    return op;
  endfunction

  task automatic issue(input int d, input op_t op, output logic [31:0] rd,
                       output logic er, output int lat, output logic tmo);
    tmo = 1'b0; lat = 0; rd = 32'h0; er = 1'b0;
    @(negedge clk);
    drive(d, op);
    req_valid[d] = 1'b1;
    for (int i = 0; i < 64 && !req_ready[d]; i++) @(negedge clk);
    if (!req_ready[d]) begin
      req_valid[d] = 1'b0;
      tmo = 1'b1;
      return;
    end
    @(negedge clk);
    req_valid[d] = 1'b0;
    tmo = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (rsp_valid[d]) begin
        tmo = 1'b0;
        rd  = rsp_rdata[d];
        er  = rsp_err[d];
        break;
      end
    end
  endtask

  task automatic test_reset();
    int cycles;
    logic [31:0] rd;
    logic er, tmo;
    int lat;
    op_t op;
    reset = 1'b1;
    op = op_t'{1'b1, 2'd2, 1'b0, 32'h3C, 32'hDEADBEEF};
    drive(0, op);
    req_valid[0] = 1'b1;
    repeat (3) @(negedge clk);
    for (int d = 0; d < NDUT; d++) begin
      n_checks++;
      if ({rsp_valid[d], rsp_err[d], rsp_rdata[d], req_ready[d], busy[d]} !== {1'b0, 1'b0, 32'h0, 1'b0, 1'b1}) begin
        n_fail++;
        $display("[TB] FAIL reset_state dut%0d: valid=%b err=%b rdata=%h ready=%b busy=%b, want 0 0 0 0 1",
                 d, rsp_valid[d], rsp_err[d], rsp_rdata[d], req_ready[d], busy[d]);
      end
    end
    reset = 1'b0;
    req_valid[0] = 1'b0;
    cycles = 0;
    while (!req_ready[0] && cycles < 100) begin
      cycles++;
      @(negedge clk);
    end
    n_checks++;
    if (cycles !== 16) begin
      n_fail++;
      $display("[TB] FAIL clear_duration: got %0d cycles not ready, want 16", cycles);
    end
    model_reset();
    op = op_t'{1'b0, 2'd2, 1'b0, 32'h3C, 32'h0};
    issue(0, op, rd, er, lat, tmo);
    n_checks++;
    if (tmo || {er, rd} !== {1'b0, model_access(0, op)}) begin
      n_fail++;
      $display("[TB] FAIL load_after_clear: got err=%b rdata=%h tmo=%b, want err=0 rdata=00000000", er, rd, tmo);
    end
  endtask

  task automatic test_store_load();
    op_t ops[$];
    logic [31:0] rd, exp;
    logic er, tmo;
    int lat;
    ops.push_back(op_t'{1'b1, 2'd2, 1'b0, 32'h10, 32'h12345678});
    ops.push_back(op_t'{1'b0, 2'd0, 1'b1, 32'h13, 32'h0});
    ops.push_back(op_t'{1'b1, 2'd0, 1'b0, 32'h11, 32'hFFFFFF80});
    ops.push_back(op_t'{1'b0, 2'd1, 1'b1, 32'h10, 32'h0});
    ops.push_back(op_t'{1'b0, 2'd0, 1'b0, 32'h11, 32'h0});
    ops.push_back(op_t'{1'b0, 2'd0, 1'b1, 32'h11, 32'h0});
    ops.push_back(op_t'{1'b0, 2'd1, 1'b0, 32'h12, 32'h0});
    ops.push_back(op_t'{1'b1, 2'd1, 1'b0, 32'h16, 32'h0000C3D2});
    ops.push_back(op_t'{1'b0, 2'd2, 1'b0, 32'h14, 32'h0});
    foreach (ops[k]) begin
      exp = model_access(0, ops[k]);
      issue(0, ops[k], rd, er, lat, tmo);
      n_checks++;
      if (tmo || {er, rd} !== {model_err(ops[k]), exp}) begin
        n_fail++;
        $display("[TB] FAIL store_load op%0d: got err=%b rdata=%h tmo=%b, want err=%b rdata=%h",
                 k, er, rd, tmo, model_err(ops[k]), exp);
      end
      n_checks++;
      if (lat != lat_of(0)) begin
        n_fail++;
        $display("[TB] FAIL store_load_latency op%0d: got %0d, want %0d", k, lat, lat_of(0));
      end
    end
  endtask

  task automatic test_misaligned();
    op_t ops[$];
    logic [31:0] rd, exp;
    logic er, tmo;
    int lat;
    ops.push_back(op_t'{1'b1, 2'd2, 1'b0, 32'h20, 32'hCAFEF00D});
    ops.push_back(op_t'{1'b1, 2'd1, 1'b0, 32'h21, 32'h0000BEEF});
    ops.push_back(op_t'{1'b0, 2'd2, 1'b0, 32'h20, 32'h0});
    ops.push_back(op_t'{1'b0, 2'd2, 1'b0, 32'h22, 32'h0});
    ops.push_back(op_t'{1'b0, 2'd3, 1'b0, 32'h20, 32'h0});
    ops.push_back(op_t'{1'b1, 2'd3, 1'b0, 32'h20, 32'h11111111});
    ops.push_back(op_t'{1'b1, 2'd2, 1'b0, 32'h23, 32'h22222222});
    ops.push_back(op_t'{1'b0, 2'd1, 1'b1, 32'h23, 32'h0});
    ops.push_back(op_t'{1'b0, 2'd2, 1'b0, 32'h20, 32'h0});
    foreach (ops[k]) begin
      exp = model_access(0, ops[k]);
      issue(0, ops[k], rd, er, lat, tmo);
      n_checks++;
      if (tmo || {er, rd} !== {model_err(ops[k]), exp}) begin
        n_fail++;
        $display("[TB] FAIL misaligned op%0d: got err=%b rdata=%h tmo=%b, want err=%b rdata=%h",
                 k, er, rd, tmo, model_err(ops[k]), exp);
      end
    end
  endtask

  task automatic test_wrap();
    op_t ops[$];
    logic [31:0] rd, exp;
    logic er, tmo;
    int lat;
    ops.push_back(op_t'{1'b1, 2'd2, 1'b0, 32'h40, 32'hA5A5A5A5});
    ops.push_back(op_t'{1'b0, 2'd2, 1'b0, 32'h00, 32'h0});
    ops.push_back(op_t'{1'b1, 2'd0, 1'b0, 32'hFFFF1043, 32'h0000005A});
    ops.push_back(op_t'{1'b0, 2'd2, 1'b0, 32'h80, 32'h0});
    foreach (ops[k]) begin
      exp = model_access(0, ops[k]);
      issue(0, ops[k], rd, er, lat, tmo);
      n_checks++;
      if (tmo || {er, rd} !== {model_err(ops[k]), exp}) begin
        n_fail++;
        $display("[TB] FAIL wrap op%0d: got err=%b rdata=%h tmo=%b, want err=%b rdata=%h",
                 k, er, rd, tmo, model_err(ops[k]), exp);
      end
    end
  endtask

  task automatic test_latency();
    op_t op;
    logic [31:0] exp;
    logic want;
    for (int t = 0; t < 3; t++) begin
      op = rand_op();
      op.wr = 1'b0;
      op.sz = 2'd2;
      op.addr[1:0] = 2'b00;
      exp = model_access(1, op);
      @(negedge clk);
      drive(1, op);
      req_valid[1] = 1'b1;
      for (int i = 0; i < 64 && !req_ready[1]; i++) @(negedge clk);
      for (int k = 0; k <= lat_of(1) + 1; k++) begin
        @(negedge clk);
        req_valid[1] = 1'b0;
        want = (k == lat_of(1));
        n_checks++;
        if ({req_ready[1], rsp_valid[1], busy[1]} !== {k >= lat_of(1), want, k < lat_of(1)}) begin
          n_fail++;
          $display("[TB] FAIL latency_handshake t%0d cycle%0d: ready=%b valid=%b busy=%b, want %b %b %b",
                   t, k, req_ready[1], rsp_valid[1], busy[1], k >= lat_of(1), want, k < lat_of(1));
        end
        if (want) begin
          n_checks++;
          if (rsp_rdata[1] !== exp) begin
            n_fail++;
            $display("[TB] FAIL latency_data t%0d: got %h, want %h", t, rsp_rdata[1], exp);
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    op_t op;
    logic [31:0] exp;
    logic exp_err;
    for (int d = 0; d < 2; d++) begin
      @(negedge clk);
      for (int j = 0; j < 6; j++) begin
        op = rand_op();
        op.addr[31:4] = '0;
        exp = model_access(d, op);
        exp_err = model_err(op);
        drive(d, op);
        req_valid[d] = 1'b1;
        n_checks++;
        if (req_ready[d] !== 1'b1) begin
          n_fail++;
          $display("[TB] FAIL b2b_ready dut%0d op%0d: got %b, want 1", d, j, req_ready[d]);
        end
        for (int k = 1; k <= lat_of(d); k++) begin
          @(negedge clk);
          n_checks++;
          if ({rsp_valid[d], req_ready[d]} !== 2'b00) begin
            n_fail++;
            $display("[TB] FAIL b2b_wait dut%0d op%0d: valid=%b ready=%b, want 0 0", d, j, rsp_valid[d], req_ready[d]);
          end
        end
        @(negedge clk);
        n_checks++;
        if ({rsp_valid[d], rsp_err[d], rsp_rdata[d]} !== {1'b1, exp_err, exp}) begin
          n_fail++;
          $display("[TB] FAIL b2b_rsp dut%0d op%0d: valid=%b err=%b rdata=%h, want 1 %b %h",
                   d, j, rsp_valid[d], rsp_err[d], rsp_rdata[d], exp_err, exp);
        end
      end
      req_valid[d] = 1'b0;
    end
  endtask

  task automatic test_reset_midflight();
    op_t op;
    int cycles;
    logic saw_rsp;
    op = op_t'{1'b0, 2'd2, 1'b0, 32'h08, 32'h0};
    @(negedge clk);
    drive(2, op);
    req_valid[2] = 1'b1;
    for (int i = 0; i < 64 && !req_ready[2]; i++) @(negedge clk);
    @(negedge clk);
    req_valid[2] = 1'b0;
    saw_rsp = rsp_valid[2];
    @(negedge clk);
    saw_rsp |= rsp_valid[2];
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    n_checks++;
    if ({req_ready[2], busy[2]} !== 2'b01) begin
      n_fail++;
      $display("[TB] FAIL midflight_clear_entry: ready=%b busy=%b, want 0 1", req_ready[2], busy[2]);
    end
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      saw_rsp |= rsp_valid[2];
      if (!req_ready[2] && cycles == i) cycles++;
      @(negedge clk);
    end
    n_checks++;
    if (saw_rsp !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL midflight_no_rsp: got rsp_valid=%b, want 0", saw_rsp);
    end
    n_checks++;
    if (cycles !== 16) begin
      n_fail++;
      $display("[TB] FAIL midflight_clear_duration: got %0d, want 16", cycles);
    end
  endtask

  task automatic test_random();
    op_t op;
    logic [31:0] rd, exp;
    logic er, tmo;
    int lat;
    for (int d = 0; d < NDUT; d++) begin
      for (int j = 0; j < 30; j++) begin
        op = rand_op();
        exp = model_access(d, op);
        issue(d, op, rd, er, lat, tmo);
        n_checks++;
        if (tmo || lat != lat_of(d) || {er, rd} !== {model_err(op), exp}) begin
          n_fail++;
          $display("[TB] FAIL random dut%0d op%0d wr=%b sz=%0d addr=%h: err=%b rdata=%h lat=%0d tmo=%b, want err=%b rdata=%h lat=%0d",
                   d, j, op.wr, op.sz, op.addr, er, rd, lat, tmo, model_err(op), exp, lat_of(d));
        end
      end
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      req_valid[d] = 1'b0;
      drive(d, op_t'{1'b0, 2'd0, 1'b0, 32'h0, 32'h0});
    end
    test_reset();
    test_store_load();
    test_misaligned();
    test_wrap();
    test_latency();
    test_back_to_back();
    test_random();
    test_reset_midflight();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
